// File: rtl/decim_capture_buffer.sv
// Debug capture of the decimated filter stream: arm, wait for a level crossing
// or forced trigger, store CAPTURE_LEN samples, then play them back over valid/ready.
module decim_capture_buffer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int CAPTURE_LEN = 256
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     din_ce,
  input  logic                     arm,
  input  logic                     force_trig,
  input  logic signed [DATA_W-1:0] trig_level,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic                     rd_last,
  output logic [1:0]               state_o,
  output logic                     done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CAPTURE_LEN - 1);

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  prev_q;
  logic                      prev_valid_q;
  logic [ADDR_W-1:0]         wr_ptr_q;
  logic [ADDR_W-1:0]         rd_ptr_q;
  logic                      rd_issued_all_q;
  logic                      ram_vld_q;
  logic signed [DATA_W-1:0]  ram_q;
  logic                      ram_last_q;
  logic signed [DATA_W-1:0]  mem [2**ADDR_W];
  logic signed [DATA_W-1:0]  buf_data_q [2];
  logic                      buf_last_q [2];
  logic                      head_q;
  logic [1:0]                cnt_q;

  logic              trig;
  logic              cap_full;
  logic              in_readout;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              pop;
  logic              push;
  logic              issue;
  logic              tail;
  logic [2:0]        occ;

  assign trig       = force_trig || (prev_valid_q && (prev_q < trig_level) && (din >= trig_level));
  assign cap_full   = (wr_ptr_q == LAST_ADDR);
  assign in_readout = (state_q == S_READOUT);
  assign wr_en      = din_ce && (((state_q == S_ARMED) && trig) ||
                                 ((state_q == S_CAPTURE) && !cap_full));
  assign wr_addr    = (state_q == S_ARMED) ? '0 : wr_ptr_q + ADDR_W'(1);

  // Output side: head of a 2-entry prefetch buffer fed by the 1-cycle RAM read.
  assign rd_valid = in_readout && (cnt_q != 2'd0);
  assign rd_data  = rd_valid ? buf_data_q[head_q] : '0;
  assign rd_last  = rd_valid && buf_last_q[head_q];
  assign pop      = rd_valid && rd_ready;
  assign done     = pop && rd_last;
  assign push     = in_readout && ram_vld_q;
  assign tail     = head_q ^ (cnt_q == 2'd1);
  // A read is issued only if buffered plus in-flight words still fit after this pop.
  assign occ      = {1'b0, cnt_q} + {2'b00, ram_vld_q};
  assign issue    = in_readout && !rd_issued_all_q && (occ <= (3'd1 + {2'b00, pop}));
  assign state_o  = state_q;

  always_ff @(posedge sys_clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (arm)            state_d = S_ARMED;
      S_ARMED:   if (din_ce && trig) state_d = S_CAPTURE;
      S_CAPTURE: if (cap_full)       state_d = S_READOUT;
      S_READOUT: if (done)           state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      prev_valid_q    <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      rd_issued_all_q <= 1'b0;
      ram_vld_q       <= 1'b0;
      cnt_q           <= 2'd0;
      head_q          <= 1'b0;
    end else begin
      if (state_q == S_IDLE)                prev_valid_q <= 1'b0;
      else if (state_q == S_ARMED && din_ce) prev_valid_q <= 1'b1;

      if (state_q == S_ARMED)               wr_ptr_q <= '0;
      else if (state_q == S_CAPTURE && wr_en) wr_ptr_q <= wr_addr;

      if (!in_readout) begin
        rd_ptr_q        <= '0;
        rd_issued_all_q <= 1'b0;
        ram_vld_q       <= 1'b0;
        cnt_q           <= 2'd0;
        head_q          <= 1'b0;
      end else begin
        ram_vld_q <= issue;
        if (issue) begin
          if (rd_ptr_q == LAST_ADDR) rd_issued_all_q <= 1'b1;
          else                       rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        end
        cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        if (pop) head_q <= ~head_q;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (state_q == S_ARMED && din_ce) prev_q <= din;
    if (wr_en) mem[wr_addr] <= din;
    if (issue) begin
      ram_q      <= mem[rd_ptr_q];
      ram_last_q <= (rd_ptr_q == LAST_ADDR);
    end
    if (push) begin
      buf_data_q[tail] <= ram_q;
      buf_last_q[tail] <= ram_last_q;
    end
  end

endmodule

// File: tb/tb_decim_capture_buffer.sv
// Bench for decim_capture_buffer: trigger-condition vector table, directed
// capture sequences and randomized captures scored against a sample-list model.
module tb_decim_capture_buffer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int LEN    = 256;

  logic                     sys_clk = 1'b0;
  logic                     reset = 1'b0;
  logic signed [DATA_W-1:0] din = '0;
  logic                     din_ce = 1'b0;
  logic                     arm = 1'b0;
  logic                     force_trig = 1'b0;
  logic signed [DATA_W-1:0] trig_level = '0;
  logic signed [DATA_W-1:0] rd_data;
  logic                     rd_valid;
  logic                     rd_ready = 1'b0;
  logic                     rd_last;
  logic [1:0]               state_o;
  logic                     done;

  decim_capture_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CAPTURE_LEN(LEN)) dut (
    .sys_clk(sys_clk), .reset(reset), .din(din), .din_ce(din_ce), .arm(arm),
    .force_trig(force_trig), .trig_level(trig_level), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .state_o(state_o), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Reference model: the list of samples strobed since arming, and the rule
  // that picks the trigger index from it.
  int s_q[$];
  bit f_q[$];
  int lvl_m;

  function automatic int find_trig();
    for (int i = 0; i < s_q.size(); i++)
      if (f_q[i] || (i > 0 && s_q[i-1] < lvl_m && s_q[i] >= lvl_m)) return i;
    return -1;
  endfunction

  // Negedge monitor of the playback port.
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  bit                       mon_on = 1'b0;
  int                       got_d[$];
  bit                       got_l[$];
  int                       got_c[$];
  int                       done_cnt = 0;
  int                       first_vld_cyc = -1;
  bit                       stall_q = 1'b0;
  logic signed [DATA_W-1:0] hold_d;
  logic                     hold_l;

  always @(negedge sys_clk) begin
    if (mon_on) begin
      if (stall_q) begin
        check("hold_valid", rd_valid, 1);
        check("hold_data", rd_data, hold_d);
        check("hold_last", rd_last, hold_l);
      end
      if (rd_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (rd_valid && rd_ready) begin
        got_d.push_back(rd_data);
        got_l.push_back(rd_last);
        got_c.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        check("done_with_last", rd_valid && rd_ready && rd_last, 1);
      end
      stall_q = rd_valid && !rd_ready;
      hold_d  = rd_data;
      hold_l  = rd_last;
    end else begin
      stall_q = 1'b0;
    end
  end

  // mode 0: ramp from -5 every 4th cycle, level 0
  // mode 1: 1000,1000,1001,1002(forced),... level 0
  // mode 2: random samples/level, arm cycle carries a sample just below level
  task automatic capture(input int mode, input int abort_at);
    int  v;
    int  k;
    bit  strobe;
    bit  stopped;
    s_q.delete();
    f_q.delete();
    lvl_m = (mode == 2) ? int'($urandom_range(2000)) - 1000 : 0;
    trig_level = 16'(lvl_m);
    arm    = 1'b1;
    din_ce = (mode == 2);
    din    = 16'(lvl_m - 1);
    tick();
    arm    = 1'b0;
    din_ce = 1'b0;
    v = -5;
    k = 0;
    stopped = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      strobe = (mode == 0) ? ((c % 4) == 3) : ($urandom_range(2) == 0);
      din_ce = strobe;
      force_trig = 1'b0;
      din = 16'($urandom);
      if (strobe) begin
        case (mode)
          0: begin din = 16'(v); v++; end
          1: begin din = 16'((k == 0) ? 1000 : 999 + k); force_trig = (k == 3); end
          default: begin
            din = 16'(int'($urandom_range(4000)) - 2000);
            if (k == 0) din = 16'(lvl_m);
            else force_trig = ($urandom_range(63) == 0);
          end
        endcase
        s_q.push_back(din);
        f_q.push_back(force_trig);
        k++;
      end
      tick();
      if (abort_at > 0 && s_q.size() >= abort_at) begin stopped = 1'b1; break; end
      if (state_o == 2'd3) begin stopped = 1'b1; break; end
    end
    din_ce = 1'b0;
    force_trig = 1'b0;
    if (!stopped) check("capture_timeout", state_o, 3);
  endtask

  task automatic readout(input bit rand_ready, input bit noise);
    int entry;
    int t;
    int exp_v;
    got_d.delete();
    got_l.delete();
    got_c.delete();
    done_cnt = 0;
    first_vld_cyc = -1;
    entry = cyc;
    mon_on = 1'b1;
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      rd_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      if (noise) begin
        din_ce     = 1'($urandom_range(1));
        force_trig = 1'($urandom_range(1));
        arm        = 1'($urandom_range(1));
        din        = 16'($urandom);
      end
      tick();
    end
    mon_on = 1'b0;
    rd_ready = 1'b0;
    din_ce = 1'b0;
    force_trig = 1'b0;
    arm = 1'b0;
    check("done_count", done_cnt, 1);
    check("idle_after_done", state_o, 0);
    check("valid_drops", rd_valid, 0);
    t = find_trig();
    if (t < 0) t = 0;
    check("word_count", got_d.size(), LEN);
    for (int i = 0; i < got_d.size() && i < LEN; i++) begin
      exp_v = (t + i < s_q.size()) ? s_q[t + i] : 32'h7fff_ffff;
      check($sformatf("word%0d", i), got_d[i], exp_v);
      check($sformatf("last%0d", i), got_l[i], (i == LEN - 1));
    end
    check("first_valid_latency", (first_vld_cyc >= entry) && (first_vld_cyc - entry <= 3), 1);
    if (!rand_ready && got_c.size() == LEN)
      check("back_to_back", got_c[LEN-1] - got_c[0], LEN - 1);
  endtask

  typedef struct {
    int lvl;
    int prev;
    int cur;
    bit frc;
    int exp_state;
  } trig_vec_t;

  trig_vec_t tv [12];
  int        bad;

  initial begin
    tv[0]  = '{0, -1, 0, 1'b0, 2};
    tv[1]  = '{0, 0, 1, 1'b0, 1};
    tv[2]  = '{0, -1, -1, 1'b0, 1};
    tv[3]  = '{100, 99, 100, 1'b0, 2};
    tv[4]  = '{100, 99, 32767, 1'b0, 2};
    tv[5]  = '{-5, -32768, -5, 1'b0, 2};
    tv[6]  = '{0, 5, -5, 1'b0, 1};
    tv[7]  = '{0, 5, 6, 1'b1, 2};
    tv[8]  = '{32767, 32766, 32767, 1'b0, 2};
    tv[9]  = '{-32768, -32768, 0, 1'b0, 1};
    tv[10] = '{0, -1, 1, 1'b0, 2};
    tv[11] = '{-10, 5, 20, 1'b0, 1};

    reset = 1'b1;
    arm   = 1'b1;
    tick();
    tick();
    check("rst_state", state_o, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_last", rd_last, 0);
    check("rst_done", done, 0);
    check("rst_data", rd_data, 0);
    reset = 1'b0;
    arm   = 1'b0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (state_o != 2'd0 || rd_valid) bad++;
    end
    check("idle_without_arm", bad, 0);

    for (int i = 0; i < 12; i++) begin
      do_reset();
      trig_level = 16'(tv[i].lvl);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check($sformatf("armed_row%0d", i), state_o, 1);
      din = 16'(tv[i].prev);
      din_ce = 1'b1;
      tick();
      din_ce = 1'b0;
      check($sformatf("first_no_cross_row%0d", i), state_o, 1);
      tick();
      din = 16'(tv[i].cur);
      force_trig = tv[i].frc;
      din_ce = 1'b1;
      tick();
      din_ce = 1'b0;
      force_trig = 1'b0;
      check($sformatf("trig_row%0d", i), state_o, tv[i].exp_state);
    end
    do_reset();

    capture(0, 0);
    readout(1'b0, 1'b0);

    capture(1, 0);
    readout(1'b1, 1'b0);

    capture(0, 105);
    check("capturing_before_reset", state_o, 2);
    do_reset();
    check("state_after_reset", state_o, 0);
    check("valid_after_reset", rd_valid, 0);

    capture(2, 0);
    readout(1'b1, 1'b1);

    capture(2, 0);
    readout(1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decim_capture_buffer.md
Name: decim_capture_buffer

Overview:
- Debug capture stage downstream of the decimating filter.
- Watches the decimated stream (16-bit signed sample plus ce_out strobe) and waits for an armed level-crossing or forced trigger.
- After the trigger, stores a fixed number of consecutive decimated samples in on-chip RAM.
- Plays the stored samples back over a valid/ready stream to a host or UART bridge, so the filter output can be inspected without a CPU.

Parameters:
- DATA_W, 16, sample width (signed, two's complement).
- ADDR_W, 8, RAM address width; depth = 2**ADDR_W.
- CAPTURE_LEN, 256, samples stored per capture; legal range 1..2**ADDR_W.

Ports:
- sys_clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- din  in  DATA_W  decimated sample (signed).
- din_ce  in  1  one-cycle strobe; din is valid only when this is high.
- arm  in  1  one-cycle pulse; arms the trigger (honoured in IDLE only).
- force_trig  in  1  level; triggers on the next din_ce while ARMED.
- trig_level  in  DATA_W  signed trigger threshold.
- rd_data  out  DATA_W  playback sample.
- rd_valid  out  1  rd_data is valid.
- rd_ready  in  1  consumer accepts.
- rd_last  out  1  high with the final playback sample.
- state_o  out  2  current state: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 READOUT.
- done  out  1  one-cycle pulse when the last sample is accepted.

Behaviour:
- Reset (synchronous, active-high) takes effect at any time, including mid-capture or mid-readout:
  - state returns to IDLE and counters clear.
  - rd_valid=0, rd_last=0, done=0, rd_data=0, state_o=0.
  - RAM contents are don't-care.
- IDLE:
  - arm=1 -> ARMED next cycle.
  - prev_valid flag clears.
  - din_ce is ignored.
- ARMED:
  - On each din_ce, the sample is latched as prev and prev_valid is set.
  - Trigger condition on din_ce: force_trig=1, or (prev_valid=1 and prev < trig_level and din >= trig_level), using signed compares.
  - The first din_ce after arming cannot fire a crossing trigger; it can fire force_trig.
  - On trigger, the triggering sample is written to address 0 and state -> CAPTURE.
- CAPTURE:
  - Each din_ce writes din to the next address (wr_ptr increments).
  - When CAPTURE_LEN samples have been written (addresses 0..CAPTURE_LEN-1), state -> READOUT on the following cycle.
  - din_ce arriving in that transition cycle is discarded.
  - arm and force_trig are ignored.
- READOUT:
  - RAM has synchronous 1-cycle read.
  - Output is a 2-entry prefetch buffer, so sustained throughput is 1 word/cycle while rd_ready=1.
  - First rd_valid asserts no later than 3 cycles after entering READOUT.
  - Samples are presented in capture order, address 0 first.
  - AXI-style handshake: transfer occurs when rd_valid && rd_ready.
  - Once rd_valid is high, rd_data and rd_last hold stable until the transfer.
  - rd_valid never drops without a transfer.
  - rd_last=1 only on sample CAPTURE_LEN-1.
  - On the last transfer: done pulses for 1 cycle, rd_valid drops next cycle, and state -> IDLE.
  - din_ce, arm and force_trig are ignored during READOUT.
- arm and din_ce in the same IDLE cycle: arm is taken and the sample is ignored; trigger evaluation starts on the next din_ce.
- Pointers never wrap inside a capture; wr_ptr and rd_ptr saturate-compare against CAPTURE_LEN-1.
- CAPTURE_LEN=1: the trigger sample alone is captured; READOUT emits one word with rd_last=1.
- Signed compare width is DATA_W; no extension or rounding is applied.

Test Plan:
- Reset with arm held, then release, no arm pulse -> state_o=0 and rd_valid=0 for 100 cycles.
- Arm, trig_level=0, ramp din -5..+300 by 1 on din_ce every 4 cycles -> trigger on din=0 (prev=-1); readout yields 0,1,...,255 with rd_last on 255 and one done pulse.
- Arm, first din_ce carries 1000 with trig_level=0 and prev invalid -> no trigger; next samples 1000,1001 -> no trigger (no crossing); force_trig=1 on the following sample 1002 -> capture starts at 1002.
- Readout with rd_ready toggled randomly (50%) -> all 256 words in order, rd_data stable while rd_valid && !rd_ready, no duplicates or gaps.
- Readout with rd_ready=1 continuously -> 256 consecutive cycles with rd_valid=1 after the first valid.
- Assert reset at capture sample 100, then arm and capture again -> state_o=0 the cycle after reset; second capture is complete and correct (starts at address 0, 256 words).
